// File: rtl/serial_adder_ctrl_if.sv
// Handshake/operand bundle for the bit-serial adder controller.
//   start  : request an addition (sampled only while idle)
//   a, b   : operands, captured on the accepted start edge
//   busy   : addition in progress
//   done   : one-cycle pulse; sum/cout valid from this cycle on
//   sum    : registered (a + b) mod 2^WIDTH
//   cout   : registered carry out of the top bit
// master = operand source side, slave = adder controller side.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands one bit per
// clock using a full adder built from two half adders plus an OR.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : serial_adder_ctrl_if.slave (start/a/b in, busy/done/sum/cout out)
// Latency: start accepted at edge T0 -> done pulse after edge T0+WIDTH.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, ADD} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, sum_q, sum_shift;
  logic [CW-1:0]    cnt;
  logic             cy, cout_q, done_q;
  logic             p, g1, s, g2, bit_carry, last;
  logic             busy, accept, finish;

  // Per-bit full adder from two half adders.
  always_comb begin
    p         = sa[0] ^ sb[0];   // half adder 1
    g1        = sa[0] & sb[0];
    s         = p ^ cy;          // half adder 2
    g2        = p & cy;
    bit_carry = g1 | g2;
    // New bit enters at the MSB; written this way so WIDTH=1 needs no special case.
    sum_shift            = sum_q >> 1;
    sum_shift[WIDTH-1]   = s;
    last                 = (cnt == LAST);
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = ADD;
      ADD:     if (last)      state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    busy   = (state == ADD);
    accept = (state == IDLE) && bus.start;
    finish = (state == ADD) && last;
  end

  // State register and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      cy     <= 1'b0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= finish;
      if (accept) begin
        sa  <= bus.a;
        sb  <= bus.b;
        cy  <= 1'b0;
        cnt <= '0;
      end else if (state == ADD) begin
        sum_q <= sum_shift;
        sa    <= sa >> 1;
        sb    <= sb >> 1;
        cy    <= bit_carry;
        cnt   <= cnt + 1'b1;
        if (last) cout_q <= bit_carry;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
